// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the in-order pipeline writeback (port A) and the
// buffered mult/div result stream (port B) onto the single register file
// write port. Port A always wins; port B drains through a DEPTH-entry FIFO.
// Optional feature macro: WB_SQUASH_EN (A writes squash queued B entries
// targeting the same register).
module writeback_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     a_valid,
   input  logic [4:0]               a_wsel,
   input  logic [31:0]              a_wdat,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [4:0]               b_wsel,
   input  logic [31:0]              b_wdat,
   output logic                     WEN,
   output logic [4:0]               wsel,
   output logic [31:0]              wdat,
   output logic [31:0]              busy,
   output logic [$clog2(DEPTH):0]   b_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0] ent_valid;
   logic [4:0]       ent_wsel [DEPTH];
   logic [31:0]      ent_wdat [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   logic a_take;
   logic pop;
   logic push;
   logic push_valid;

   // Backpressure depends only on the registered occupancy
   assign b_ready = (b_count != CW'(DEPTH));

   // Slot arbitration: a write to r0 never claims the slot
   always_comb begin
      a_take = a_valid && (a_wsel != 5'd0);
      pop    = !a_take && (b_count != '0);
      push   = b_valid && b_ready && (b_wsel != 5'd0);
`ifdef WB_SQUASH_EN
      push_valid = !(a_take && (b_wsel == a_wsel));
`else
      push_valid = 1'b1;
`endif
   end

   // Entry valid bits: cleared on pop (and on squash), set on enqueue
   always_ff @(posedge CLK) begin
      if (RST) begin
         ent_valid <= '0;
      end else begin
`ifdef WB_SQUASH_EN
         if (a_take) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent_wsel[i] == a_wsel) ent_valid[i] <= 1'b0;
            end
         end
`endif
         if (pop)  ent_valid[rd_ptr] <= 1'b0;
         if (push) ent_valid[wr_ptr] <= push_valid;
      end
   end

   // Entry payload storage; only meaningful while the valid bit is set
   always_ff @(posedge CLK) begin
      if (push) begin
         ent_wsel[wr_ptr] <= b_wsel;
         ent_wdat[wr_ptr] <= b_wdat;
      end
   end

   // Pointers wrap naturally modulo DEPTH; the counter separates full/empty
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         b_count <= '0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         case ({push, pop})
            2'b10:   b_count <= b_count + CW'(1);
            2'b01:   b_count <= b_count - CW'(1);
            default: b_count <= b_count;
         endcase
      end
   end

   // Registered register-file write port
   always_ff @(posedge CLK) begin
      if (RST) begin
         WEN  <= 1'b0;
         wsel <= 5'd0;
         wdat <= 32'd0;
      end else if (a_take) begin
         WEN  <= 1'b1;
         wsel <= a_wsel;
         wdat <= a_wdat;
      end else if (pop && ent_valid[rd_ptr]) begin
         WEN  <= 1'b1;
         wsel <= ent_wsel[rd_ptr];
         wdat <= ent_wdat[rd_ptr];
      end else begin
         WEN  <= 1'b0;
         wsel <= 5'd0;
         wdat <= 32'd0;
      end
   end

   // In-flight register mask for the hazard unit
   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i]) busy[ent_wsel[i]] = 1'b1;
      end
      if (WEN) busy[wsel] = 1'b1;
      busy[0] = 1'b0;
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus hand sequences
// for backpressure/wrap, squash and mid-operation reset.
module tb_writeback_arbiter;

   localparam int unsigned DEPTH = 4;

   logic        CLK;
   logic        RST;
   logic        a_valid;
   logic [4:0]  a_wsel;
   logic [31:0] a_wdat;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_wsel;
   logic [31:0] b_wdat;
   logic        WEN;
   logic [4:0]  wsel;
   logic [31:0] wdat;
   logic [31:0] busy;
   logic [$clog2(DEPTH):0] b_count;

   int n_tests;
   int n_fail;

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .a_valid(a_valid), .a_wsel(a_wsel), .a_wdat(a_wdat),
      .b_valid(b_valid), .b_ready(b_ready), .b_wsel(b_wsel), .b_wdat(b_wdat),
      .WEN(WEN), .wsel(wsel), .wdat(wdat), .busy(busy), .b_count(b_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        a_v;
      logic [4:0]  a_s;
      logic [31:0] a_d;
      logic        b_v;
      logic [4:0]  b_s;
      logic [31:0] b_d;
      logic        e_wen;
      logic [4:0]  e_wsel;
      logic [31:0] e_wdat;
      int          e_cnt;
      logic        e_rdy;
      logic [31:0] e_busy;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic av, input logic [4:0] as, input logic [31:0] ad,
                        input logic bv, input logic [4:0] bs, input logic [31:0] bd);
      a_valid = av; a_wsel = as; a_wdat = ad;
      b_valid = bv; b_wsel = bs; b_wdat = bd;
   endtask

   task automatic check_port(input string tag, input logic ew, input logic [4:0] es,
                             input logic [31:0] ed, input int ec, input logic [31:0] eb);
      check({tag, ".WEN"},     32'(WEN), 32'(ew));
      check({tag, ".wsel"},    32'(wsel), 32'(es));
      check({tag, ".wdat"},    wdat, ed);
      check({tag, ".b_count"}, 32'(b_count), 32'(ec));
      check({tag, ".busy"},    busy, eb);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // Reset held two cycles with all inputs active
      RST = 1'b1;
      drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
      step();
      step();
      check_port("reset", 1'b0, 5'd0, 32'h0, 0, 32'h0);
      check("reset.b_ready", 32'(b_ready), 32'h1);
      RST = 1'b0;

      // Vector table: inputs for one edge, outputs expected after it
      vecs[0] = '{1'b1, 5'd5, 32'h11,   1'b1, 5'd6, 32'h22,   1'b1, 5'd5, 32'h11,   1, 1'b1, 32'h60};
      vecs[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd6, 32'h22,   0, 1'b1, 32'h40};
      vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    0, 1'b1, 32'h0};
      vecs[3] = '{1'b1, 5'd0, 32'h55,   1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 32'h0,    1, 1'b1, 32'h200};
      vecs[4] = '{1'b1, 5'd0, 32'h66,   1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hABCD, 0, 1'b1, 32'h200};
      vecs[5] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h77,   1'b0, 5'd0, 32'h0,    0, 1'b1, 32'h0};
      vecs[6] = '{1'b1, 5'd1, 32'hDEAD, 1'b0, 5'd0, 32'h0,    1'b1, 5'd1, 32'hDEAD, 0, 1'b1, 32'h2};
      vecs[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    0, 1'b1, 32'h0};

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].a_v, vecs[i].a_s, vecs[i].a_d, vecs[i].b_v, vecs[i].b_s, vecs[i].b_d);
         step();
         check_port($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_wsel, vecs[i].e_wdat,
                    vecs[i].e_cnt, vecs[i].e_busy);
         check($sformatf("vec%0d.b_ready", i), 32'(b_ready), 32'(vecs[i].e_rdy));
      end

      // Fill with A continuously busy on r7; write pointer wraps during fill
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("fill%0d.ready_before", k), 32'(b_ready), 32'h1);
         drive(1'b1, 5'd7, 32'h700 + 32'(k), 1'b1, 5'(k), 32'h100 + 32'(k));
         step();
         check_port($sformatf("fill%0d", k), 1'b1, 5'd7, 32'h700 + 32'(k), k,
                    (32'h1E >> (4 - k)) & 32'h1E | 32'h80);
      end
      check("full.b_ready", 32'(b_ready), 32'h0);
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 5'd7, 32'h7F0, 1'b1, 5'd5, 32'h105);
         step();
         check_port($sformatf("stall%0d", k), 1'b1, 5'd7, 32'h7F0, 4, 32'h9E);
         check($sformatf("stall%0d.b_ready", k), 32'(b_ready), 32'h0);
      end

      // A idle: r1..r5 retire back to back; r5 enters once a slot frees
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h105);
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 2) b_valid = 1'b0;
         check($sformatf("drain%0d.WEN", k),  32'(WEN), 32'h1);
         check($sformatf("drain%0d.wsel", k), 32'(wsel), 32'(k));
         check($sformatf("drain%0d.wdat", k), wdat, 32'h100 + 32'(k));
         check($sformatf("drain%0d.b_count", k), 32'(b_count), (k <= 2) ? 32'd3 : 32'(5 - k));
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step();
      check_port("drained", 1'b0, 5'd0, 32'h0, 0, 32'h0);

      // Queued r3 entry followed by an A write to r3
      drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd3, 32'h1);
      step();
      check_port("sq.enq", 1'b1, 5'd8, 32'h8, 1, 32'h108);
      drive(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'h0);
      step();
      check_port("sq.awr", 1'b1, 5'd3, 32'h2, 1, 32'h8);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step();
`ifdef WB_SQUASH_EN
      check_port("sq.pop", 1'b0, 5'd0, 32'h0, 0, 32'h0);
`else
      check_port("sq.pop", 1'b1, 5'd3, 32'h1, 0, 32'h8);
`endif
      step();
      check_port("sq.idle", 1'b0, 5'd0, 32'h0, 0, 32'h0);

      // Mid-operation reset discards three queued entries
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 5'd10, 32'hA0 + 32'(k), 1'b1, 5'(11 + k), 32'hB0 + 32'(k));
         step();
      end
      check("mr.queued", 32'(b_count), 32'd3);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      RST = 1'b1;
      step();
      RST = 1'b0;
      check_port("mr.reset", 1'b0, 5'd0, 32'h0, 0, 32'h0);
      check("mr.b_ready", 32'(b_ready), 32'h1);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("mr.quiet%0d.WEN", k), 32'(WEN), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
